// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO input peripheral: register offsets, bus width
// and the default debounce length.
package gpio_pkg;

  localparam int BUS_W            = 32;
  localparam int DEBOUNCE_DEFAULT = 4;

  localparam logic [1:0] GPIO_DATA = 2'd0;
  localparam logic [1:0] GPIO_EDGE = 2'd1;
  localparam logic [1:0] GPIO_MASK = 2'd2;

endpackage

// File: rtl/gpio_debounce.sv
// One input pin: two-flop synchronizer followed by a debounce counter.
// rise is combinational and marks the edge on which stable goes 0 -> 1.
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic stable,
  output logic rise
);

  localparam int              CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          accept;

  // A new level is accepted once it has been seen DEBOUNCE_CYCLES times in a row.
  assign accept = (s2 != stable) && (cnt == CNT_MAX);
  assign rise   = accept && s2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      if (s2 != stable) begin
        if (accept) begin
          stable <= s2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/gpio_input_port.sv
// Memory-mapped GPIO input port: debounced DATA, sticky rising-edge EDGE (W1C),
// interrupt MASK, registered read port and level IRQ.
module gpio_input_port
  import gpio_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] GPIO_i,
  input  logic             Rd_En,
  input  logic             Wr_En,
  input  logic [1:0]       Addr,
  input  logic [BUS_W-1:0] Wr_Data,
  output logic [BUS_W-1:0] Rd_Data,
  output logic             IRQ
);

  logic [WIDTH-1:0] stable_v;
  logic [WIDTH-1:0] rise_v;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] edge_clr;
  logic [BUS_W-1:0] rd_next;
  logic             unused_wr;

  assign unused_wr = ^Wr_Data;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk   (clk),
      .reset (reset),
      .pin   (GPIO_i[i]),
      .stable(stable_v[i]),
      .rise  (rise_v[i])
    );
  end

  assign edge_clr = (Wr_En && Addr == GPIO_EDGE) ? Wr_Data[WIDTH-1:0] : '0;

  always_comb begin
    rd_next = '0;
    case (Addr)
      GPIO_DATA: rd_next = BUS_W'(stable_v);
      GPIO_EDGE: rd_next = BUS_W'(edge_q);
      GPIO_MASK: rd_next = BUS_W'(mask_q);
      default:   rd_next = '0;
    endcase
  end

  // Set is OR'd in after the clear so a simultaneous new edge survives the W1C.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      edge_q  <= '0;
      mask_q  <= '0;
      Rd_Data <= '0;
      IRQ     <= 1'b0;
    end else begin
      edge_q <= (edge_q & ~edge_clr) | rise_v;
      if (Wr_En && Addr == GPIO_MASK) mask_q <= Wr_Data[WIDTH-1:0];
      if (Rd_En) Rd_Data <= rd_next;
      IRQ <= |(edge_q & mask_q);
    end
  end

endmodule

// File: tb/tb_gpio_input_port.sv
// Directed bench for gpio_input_port: reads push expected values into a queue
// and a monitor compares them against Rd_Data one edge later.
module tb_gpio_input_port;
  import gpio_pkg::*;

  logic        clk;
  logic        reset;
  logic [7:0]  GPIO_i;
  logic        Rd_En;
  logic        Wr_En;
  logic [1:0]  Addr;
  logic [31:0] Wr_Data;
  logic [31:0] Rd_Data;
  logic        IRQ;

  logic [31:0] exp_q[$];
  string       name_q[$];
  int          n_checks;
  int          n_fail;

  gpio_input_port #(
    .WIDTH(8),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .GPIO_i (GPIO_i),
    .Rd_En  (Rd_En),
    .Wr_En  (Wr_En),
    .Addr   (Addr),
    .Wr_Data(Wr_Data),
    .Rd_Data(Rd_Data),
    .IRQ    (IRQ)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: Rd_Data is valid just after the edge that sampled Rd_En
  always @(posedge clk) begin
    if (reset && Rd_En) begin
      #1;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL read_unexpected: got 0x%0h, expected no read", Rd_Data);
      end else begin
        check(name_q.pop_front(), Rd_Data, exp_q.pop_front());
      end
    end
  end

  // driver tasks: all start and end on a negedge
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    Rd_En = 1'b1;
    Addr  = a;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(negedge clk);
    Rd_En = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Wr_En   = 1'b1;
    Addr    = a;
    Wr_Data = d;
    @(negedge clk);
    Wr_En   = 1'b0;
    Wr_Data = '0;
  endtask

  task automatic rdwr(input logic [1:0] a, input logic [31:0] d, input logic [31:0] exp,
                      input string name);
    Rd_En   = 1'b1;
    Wr_En   = 1'b1;
    Addr    = a;
    Wr_Data = d;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(negedge clk);
    Rd_En   = 1'b0;
    Wr_En   = 1'b0;
    Wr_Data = '0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    GPIO_i   = '0;
    Rd_En    = 1'b0;
    Wr_En    = 1'b0;
    Addr     = '0;
    Wr_Data  = '0;
    #1;
    check("por_rd_data", Rd_Data, 32'h0);
    check("por_irq", {31'b0, IRQ}, 32'h0);
    cyc(2);
    reset = 1'b1;

    // reset mid-run with MASK=0xFF and EDGE=0x0F
    GPIO_i = 8'h0F;
    wr(GPIO_MASK, 32'hFF);
    cyc(8);
    check("rst_pre_irq", {31'b0, IRQ}, 32'h1);
    rd(GPIO_EDGE, 32'h0F, "rst_pre_edge");
    #2 reset = 1'b0;
    #1;
    check("rst_async_rd_data", Rd_Data, 32'h0);
    check("rst_async_irq", {31'b0, IRQ}, 32'h0);
    GPIO_i = 8'h00;
    cyc(2);
    reset = 1'b1;
    rd(GPIO_DATA, 32'h00, "rst_data");
    rd(GPIO_EDGE, 32'h00, "rst_edge");
    rd(GPIO_MASK, 32'h00, "rst_mask");

    // clean rise on pin 3; pin captured at edge k
    wr(GPIO_MASK, 32'h08);
    GPIO_i[3] = 1'b1;
    cyc(4);
    rd(GPIO_DATA, 32'h00, "rise_data_k4");
    check("rise_irq_k4", {31'b0, IRQ}, 32'h0);
    rd(GPIO_DATA, 32'h00, "rise_data_k5_pre");
    check("rise_irq_k5", {31'b0, IRQ}, 32'h0);
    rd(GPIO_EDGE, 32'h08, "rise_edge_k6");
    check("rise_irq_k6", {31'b0, IRQ}, 32'h1);
    rd(GPIO_DATA, 32'h08, "rise_data_k7");

    // W1C clear, IRQ drops one edge later
    wr(GPIO_EDGE, 32'h08);
    check("clr_irq_same", {31'b0, IRQ}, 32'h1);
    cyc(1);
    check("clr_irq_next", {31'b0, IRQ}, 32'h0);
    rd(GPIO_EDGE, 32'h00, "clr_edge");

    // falling edge and reserved offset
    GPIO_i[3] = 1'b0;
    cyc(8);
    rd(GPIO_DATA, 32'h00, "fall_data");
    rd(GPIO_EDGE, 32'h00, "fall_edge");
    rd(2'd3, 32'h00, "rsvd_read");
    wr(GPIO_DATA, 32'hFF);
    wr(2'd3, 32'hFF);
    rd(GPIO_DATA, 32'h00, "ro_data");
    rd(GPIO_MASK, 32'h08, "rsvd_wr_mask");
    rd(GPIO_EDGE, 32'h00, "rsvd_wr_edge");

    // glitches of 3 cycles, the second after a 1-cycle gap
    GPIO_i[0] = 1'b1;
    cyc(3);
    GPIO_i[0] = 1'b0;
    cyc(8);
    rd(GPIO_DATA, 32'h00, "glitch_data");
    rd(GPIO_EDGE, 32'h00, "glitch_edge");
    GPIO_i[0] = 1'b1;
    cyc(3);
    GPIO_i[0] = 1'b0;
    cyc(1);
    GPIO_i[0] = 1'b1;
    cyc(3);
    GPIO_i[0] = 1'b0;
    cyc(8);
    rd(GPIO_DATA, 32'h00, "glitch2_data");
    rd(GPIO_EDGE, 32'h00, "glitch2_edge");

    // 5-cycle pulse is accepted
    GPIO_i[0] = 1'b1;
    cyc(5);
    GPIO_i[0] = 1'b0;
    cyc(1);
    rd(GPIO_DATA, 32'h01, "pulse5_data");
    cyc(8);
    rd(GPIO_EDGE, 32'h01, "pulse5_edge");
    rd(GPIO_DATA, 32'h00, "pulse5_data_after");

    // W1C collides with a newly accepted rise on bit 0
    wr(GPIO_MASK, 32'h01);
    GPIO_i[0] = 1'b1;
    cyc(5);
    wr(GPIO_EDGE, 32'h01);
    rd(GPIO_EDGE, 32'h01, "w1c_collide_edge");
    check("w1c_collide_irq", {31'b0, IRQ}, 32'h1);
    wr(GPIO_EDGE, 32'h01);
    check("w1c_irq_same", {31'b0, IRQ}, 32'h1);
    cyc(1);
    check("w1c_irq_next", {31'b0, IRQ}, 32'h0);
    rd(GPIO_EDGE, 32'h00, "w1c_edge");

    // same-cycle read and write at MASK
    wr(GPIO_MASK, 32'h0F);
    rdwr(GPIO_MASK, 32'hF0, 32'h0F, "rdwr_old");
    rd(GPIO_MASK, 32'hF0, "rdwr_new");
    cyc(2);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
